// File: rtl/mux_4_1_arbiter_if.sv
// Bundle of the 4-requester arbiter: request/data inputs, combinational grants
// and the registered single-word output with its valid/ready handshake.
interface mux_4_1_arbiter_if #(
  parameter int unsigned W = 4
);
  logic [3:0]   req;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic         rr_en;
  logic [3:0]   ack;
  logic [W-1:0] y;
  logic [1:0]   y_src;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output req, d0, d1, d2, d3, rr_en, out_ready,
    input  ack, y, y_src, out_valid
  );

  modport slave (
    input  req, d0, d1, d2, d3, rr_en, out_ready,
    output ack, y, y_src, out_valid
  );
endinterface

// File: rtl/mux_4_1_arbiter.sv
// 4:1 arbitrating mux with round-robin or fixed-priority selection feeding a
// one-word output register (EMPTY/FULL) with a valid/ready handshake.
module mux_4_1_arbiter #(
  parameter int unsigned W = 4
) (
  input logic              clk,
  input logic              rst,
  mux_4_1_arbiter_if.slave bus
);
  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e       state_q;
  logic [1:0]   ptr_q;
  logic [W-1:0] y_q;
  logic [1:0]   y_src_q;

  logic         out_valid;
  logic         handshake;
  logic         load;
  logic [1:0]   winner;
  logic [1:0]   idx;
  logic         found;
  logic [W-1:0] win_data;

  assign out_valid = (state_q == StFull);
  assign handshake = out_valid && bus.out_ready;
  assign load      = (|bus.req) && (!out_valid || bus.out_ready);

  always_comb begin
    winner = 2'd0;
    idx    = 2'd0;
    found  = 1'b0;
    if (bus.rr_en) begin
      // Search starts at ptr and wraps modulo 4.
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!found && bus.req[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (bus.req[k]) begin
          winner = 2'(k);
        end
      end
    end
  end

  always_comb begin
    win_data = bus.d0;
    unique case (winner)
      2'd0: win_data = bus.d0;
      2'd1: win_data = bus.d1;
      2'd2: win_data = bus.d2;
      2'd3: win_data = bus.d3;
      default: win_data = bus.d0;
    endcase
  end

  always_comb begin
    bus.ack = 4'b0000;
    if (load && !rst) begin
      bus.ack[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      ptr_q   <= 2'd0;
      y_q     <= '0;
      y_src_q <= 2'd0;
    end else if (load) begin
      state_q <= StFull;
      y_q     <= win_data;
      y_src_q <= winner;
      ptr_q   <= winner + 2'd1;
    end else if (handshake) begin
      state_q <= StEmpty;
    end
  end

  assign bus.y         = y_q;
  assign bus.y_src     = y_src_q;
  assign bus.out_valid = out_valid;
endmodule

// File: doc/mux_4_1_arbiter.md
MUX_4_1_ARBITER -- requirements
Module: mux_4_1_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, giving the data width of each requester channel and of the output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i presents valid data on di.
REQ-005 SHALL have ports d0, d1, d2 and d3, each input, W bits: requester data.
REQ-006 SHALL have port rr_en, input, 1 bit: 1 selects round-robin arbitration, 0 selects fixed priority (0 highest).
REQ-007 SHALL have port ack, output, 4 bits: one-hot, combinational; ack[i] high means di is captured at this edge.
REQ-008 SHALL have port y, output, W bits: registered winning data.
REQ-009 SHALL have port y_src, output, 2 bits: registered index of the requester that supplied y.
REQ-010 SHALL have port out_valid, output, 1 bit: y and y_src hold an unconsumed word.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts y when out_valid and out_ready are both high.

Function
REQ-012 SHALL define load = (|req) && (!out_valid || out_ready).
REQ-013 SHALL define the winner for round-robin mode (rr_en=1) as the first set req bit, searching ptr, ptr+1, ... modulo 4.
REQ-014 SHALL define the winner for fixed-priority mode (rr_en=0) as the lowest-index set req bit, with ptr ignored for selection.
REQ-015 SHALL, when load is high, assert ack[winner] alone and capture at the edge: y<=d[winner], y_src<=winner, out_valid<=1.
REQ-016 SHALL, when load is high, update ptr<=(winner+1) mod 4 at the edge in both modes, with 3 wrapping to 0.
REQ-017 SHALL hold ack at 4'b0000 whenever load is low, including when req is nonzero and the output is stalled.
REQ-018 SHALL, when load is low and out_valid && out_ready, clear out_valid and leave y and y_src unchanged.
REQ-019 SHALL, when load is low and no handshake occurs, hold y, y_src, out_valid and ptr unchanged.
REQ-020 SHALL operate as a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY to FULL on load.
- FULL to FULL on handshake with load (back-to-back transfer).
- FULL to EMPTY on handshake without load.
- FULL holds without handshake.
REQ-021 SHALL have latency of 1 cycle: req high at edge N while EMPTY produces out_valid=1 with y=d[winner] after edge N.
REQ-022 SHALL sustain throughput of one word per cycle while out_ready stays high and req is nonzero.
REQ-023 SHALL ignore out_ready while out_valid=0.
REQ-024 SHALL keep the word at y stable while FULL and out_ready=0, whatever req and d do.
REQ-025 SHALL let a requester that has not yet been acked hold req; no starvation is permitted in round-robin mode (every waiting requester is served within 4 loads).
REQ-026 SHALL take the effect of an rr_en change at the next load; ptr is maintained in both modes.

Reset
REQ-027 SHALL, while rst is high, force out_valid=0, y=0, y_src=0 and ptr=0 immediately, without waiting for a clock edge.
REQ-028 SHALL, while rst is high, force ack=4'b0000.
REQ-029 SHALL drop any pending output word when rst is asserted mid-transfer; no ack is reissued for it.
REQ-030 SHALL evaluate the first load on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover: rr_en=1, req=4'b1111, out_ready=1, after reset -> y_src sequence 0,1,2,3,0; ack one-hot in the same order; out_valid continuously 1.
REQ-032 SHALL cover: rr_en=0, req=4'b1010 held, out_ready=1 -> y_src always 1; ack=4'b0010 every cycle.
REQ-033 SHALL cover: one word loaded, then out_ready=0 for 3 cycles with d changing -> y and y_src frozen; ack=0 throughout; word consumed on the first cycle out_ready=1.
REQ-034 SHALL cover: ptr=3 (after serving 2), req=4'b0101 -> winner 0 (wrap), then winner 2.
REQ-035 SHALL cover: req=0, out_valid=1, out_ready=1 -> out_valid=0 next cycle; ptr unchanged.
REQ-036 SHALL cover: rst asserted between clock edges while FULL -> out_valid, y and y_src read 0 before the next edge; after release with req=4'b0100 -> y_src=2 after 1 cycle.
